// File: rtl/cpu_pkg.sv
// Shared definitions for the program-load sequencer: controller states,
// default stream framing symbols and the default symbol width.
package cpu_pkg;

    localparam int         BYTE_W_DEF    = 8;
    localparam logic [7:0] START_TOK_DEF = 8'hFE;
    localparam logic [7:0] END_TOK_DEF   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_READ = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // 11-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs stream symbols into memory words, first symbol in the low slot.
// A completed word (or a flushed, zero-padded partial word) is presented
// on word with a one-cycle word_valid pulse the cycle after it completes.
module byte_packer #(
    parameter int  BYTE_W     = 8,
    parameter int  WORD_BYTES = 4,
    localparam int CW         = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [BYTE_W-1:0]            data,
    input  logic                         flush,
    input  logic                         clear,
    output logic [BYTE_W*WORD_BYTES-1:0] word,
    output logic                         word_valid
);

    logic [WORD_BYTES-1:0][BYTE_W-1:0] acc_reg;
    logic [WORD_BYTES-1:0][BYTE_W-1:0] acc_next;
    logic [CW-1:0]                     cnt_reg;
    logic [BYTE_W*WORD_BYTES-1:0]      word_reg;
    logic                              word_valid_reg;
    logic                              emit;

    // Each slot takes the incoming symbol only when the fill count points at it.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_slot
            assign acc_next[gi] = (push && cnt_reg == CW'(gi)) ? data : acc_reg[gi];
        end
    endgenerate

    // A word leaves when its last slot fills, or on flush if anything is pending.
    assign emit = (push && cnt_reg == CW'(WORD_BYTES - 1)) || (flush && cnt_reg != '0);

    // Accumulator, fill count and registered output word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_reg        <= '0;
            cnt_reg        <= '0;
            word_reg       <= '0;
            word_valid_reg <= 1'b0;
        end else begin
            word_valid_reg <= emit;
            if (emit) begin
                word_reg <= acc_next;
            end
            if (clear || emit) begin
                acc_reg <= '0;
                cnt_reg <= '0;
            end else if (push) begin
                acc_reg <= acc_next;
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign word       = word_reg;
    assign word_valid = word_valid_reg;

endmodule

// File: rtl/prog_load_ctrl.sv
// Load / run / readback sequencer in front of the CPU core. Loads a framed
// byte stream into IMEM, runs the CPU for a bounded time, then walks the
// requested vector-register lanes and counts mismatches against a ROM.
module prog_load_ctrl
    import cpu_pkg::*;
#(
    parameter int              BYTE_W     = BYTE_W_DEF,
    parameter int              WORD_BYTES = 4,
    parameter int              IMEM_DEPTH = 64,
    parameter int              LANES      = 4,
    parameter int              RUN_CYCLES = 224,
    parameter logic [BYTE_W-1:0] START_TOK = BYTE_W'(START_TOK_DEF),
    parameter logic [BYTE_W-1:0] END_TOK   = BYTE_W'(END_TOK_DEF),
    localparam int             AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1,
    localparam int             LW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset,
    input  logic                         byte_valid_i,
    input  logic [BYTE_W-1:0]            byte_i,
    input  logic [4:0]                   rb_first_i,
    input  logic [4:0]                   rb_count_i,
    input  logic                         cpu_halt_i,
    input  logic [BYTE_W-1:0]            rd_value_i,
    input  logic [BYTE_W-1:0]            exp_i,
    output logic                         imem_we_o,
    output logic [AW-1:0]                imem_addr_o,
    output logic [BYTE_W*WORD_BYTES-1:0] imem_wdata_o,
    output logic                         cpu_run_o,
    output logic [4:0]                   rd_reg_o,
    output logic [LW-1:0]                rd_lane_o,
    output logic [10:0]                  exp_idx_o,
    output logic [10:0]                  err_cnt_o,
    output logic                         overflow_o,
    output logic                         done_o
);

    localparam int RCW = $clog2(RUN_CYCLES + 1);

    state_t                       state_reg, state_next;
    logic                         is_start, is_end, in_load;
    logic                         pack_push, pack_flush, pack_clear;
    logic [BYTE_W*WORD_BYTES-1:0] pack_word;
    logic                         pack_valid;
    logic [AW-1:0]                addr_reg;
    logic                         full_reg, overflow_reg, ending_reg;
    logic [RCW-1:0]               run_cnt_reg;
    logic                         run_exit;
    logic [4:0]                   reg_idx_reg, regs_left_reg;
    logic [LW-1:0]                lane_reg;
    logic                         issue_done_reg, issuing, last_issue;
    logic                         cmp_valid_reg, cmp_last_reg;
    logic [10:0]                  exp_idx_reg, err_cnt_reg;

    assign is_start = byte_valid_i && (byte_i == START_TOK);
    assign is_end   = byte_valid_i && (byte_i == END_TOK);
    // ending_reg marks the one cycle where the padded tail word is written;
    // the stream is ignored during it.
    assign in_load    = (state_reg == ST_LOAD) && !ending_reg;
    assign pack_push  = in_load && byte_valid_i && !is_start && !is_end;
    assign pack_flush = in_load && is_end;
    assign pack_clear = ((state_reg == ST_IDLE) || in_load) && is_start;

    // Halt and timer expiry on the same cycle are naturally one exit.
    assign run_exit   = (state_reg == ST_RUN) &&
                        (cpu_halt_i || run_cnt_reg == RCW'(RUN_CYCLES - 1));
    assign issuing    = (state_reg == ST_READ) && !issue_done_reg;
    assign last_issue = issuing && lane_reg == '0 && regs_left_reg == 5'd1;

    byte_packer #(
        .BYTE_W    (BYTE_W),
        .WORD_BYTES(WORD_BYTES)
    ) u_packer (
        .clk       (clk_i),
        .reset     (reset),
        .push      (pack_push),
        .data      (byte_i),
        .flush     (pack_flush),
        .clear     (pack_clear),
        .word      (pack_word),
        .word_valid(pack_valid)
    );

    // Next-state selection for the sequencer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (is_start) state_next = ST_LOAD;
            ST_LOAD: if (ending_reg) state_next = ST_RUN;
            ST_RUN:  if (run_exit) state_next = (rb_count_i == 5'd0) ? ST_DONE : ST_READ;
            ST_READ: if (cmp_valid_reg && cmp_last_reg) state_next = ST_DONE;
            ST_DONE: state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register, tail-write marker and run timer.
    always_ff @(posedge clk_i) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            ending_reg  <= 1'b0;
            run_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            ending_reg  <= pack_flush;
            run_cnt_reg <= (state_reg == ST_RUN) ? run_cnt_reg + RCW'(1) : '0;
        end
    end

    // IMEM address: advances after each write, parks on the last word, and
    // flags any word that arrives once the memory is full.
    always_ff @(posedge clk_i) begin
        if (!reset) begin
            addr_reg     <= '0;
            full_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (pack_valid && full_reg) begin
                overflow_reg <= 1'b1;
            end
            if (pack_clear) begin
                addr_reg <= '0;
                full_reg <= 1'b0;
            end else if (pack_valid && !full_reg) begin
                if (addr_reg == AW'(IMEM_DEPTH - 1)) begin
                    full_reg <= 1'b1;
                end else begin
                    addr_reg <= addr_reg + AW'(1);
                end
            end
        end
    end

    // Readback: issue (reg, lane) pairs, then compare one cycle later when
    // the CPU's lane value arrives. The last pair is held while it compares.
    always_ff @(posedge clk_i) begin
        if (!reset) begin
            reg_idx_reg    <= '0;
            lane_reg       <= '0;
            regs_left_reg  <= '0;
            issue_done_reg <= 1'b0;
            cmp_valid_reg  <= 1'b0;
            cmp_last_reg   <= 1'b0;
            exp_idx_reg    <= '0;
            err_cnt_reg    <= '0;
        end else begin
            cmp_valid_reg <= issuing;
            cmp_last_reg  <= last_issue;
            if (run_exit && rb_count_i != 5'd0) begin
                reg_idx_reg    <= rb_first_i;
                lane_reg       <= LW'(LANES - 1);
                regs_left_reg  <= rb_count_i;
                issue_done_reg <= 1'b0;
            end else if (issuing) begin
                if (lane_reg != '0) begin
                    lane_reg <= lane_reg - LW'(1);
                end else if (regs_left_reg == 5'd1) begin
                    issue_done_reg <= 1'b1;
                end else begin
                    reg_idx_reg   <= reg_idx_reg + 5'd1;
                    lane_reg      <= LW'(LANES - 1);
                    regs_left_reg <= regs_left_reg - 5'd1;
                end
            end
            if (cmp_valid_reg) begin
                exp_idx_reg <= exp_idx_reg + 11'd1;
                if (rd_value_i != exp_i) begin
                    err_cnt_reg <= sat_inc11(err_cnt_reg);
                end
            end
        end
    end

    assign imem_we_o    = pack_valid && !full_reg;
    assign imem_addr_o  = addr_reg;
    assign imem_wdata_o = pack_word;
    assign cpu_run_o    = (state_reg == ST_RUN);
    assign rd_reg_o     = reg_idx_reg;
    assign rd_lane_o    = lane_reg;
    assign exp_idx_o    = exp_idx_reg;
    assign err_cnt_o    = err_cnt_reg;
    assign overflow_o   = overflow_reg;
    assign done_o       = (state_reg == ST_DONE);

endmodule
